// File: rtl/fb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// fb_sram_arbiter
//
// Shares one single-port framebuffer SRAM (one access per cycle) between the
// VGA pixel fetch and two game-side clients (A = game logic, B = clear/fill
// engine), and implements double buffering on top of it:
//   - VGA always reads the front buffer, clients always touch the back buffer.
//   - A requested swap is applied only at the start of vertical sync, so the
//     displayed frame never tears.
//
// Ports
//   iCLK, iRST_N               pixel clock, asynchronous active-low reset
//   iVGA_REQ/iVGA_ADDR         display fetch strobe and word address
//   oVGA_DATA/oVGA_VALID       display read data, valid two cycles after REQ
//   iVGA_VSYNC                 active-low vertical sync
//   iX_REQ/WE/ADDR/WDATA       client request (X = A, B), held until granted
//   oX_GNT                     combinational grant
//   oX_RDATA/oX_RVALID         client read data, valid two cycles after grant
//   iSWAP_REQ                  single-cycle swap request
//   oFRONT_SEL                 front buffer index
//   oSWAP_PEND/oSWAP_DONE      swap waiting for vsync / one-cycle swap pulse
//   oSRAM_*                    SRAM pins: {buffer, word} address, data out,
//                              data in, DQ drive enable, WE_N, OE_N
// ---------------------------------------------------------------------------
module fb_sram_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  // display fetch
  input  logic              iVGA_REQ,
  input  logic [ADDR_W-1:0] iVGA_ADDR,
  output logic [DATA_W-1:0] oVGA_DATA,
  output logic              oVGA_VALID,
  input  logic              iVGA_VSYNC,
  // client A
  input  logic              iA_REQ,
  input  logic              iA_WE,
  input  logic [ADDR_W-1:0] iA_ADDR,
  input  logic [DATA_W-1:0] iA_WDATA,
  output logic              oA_GNT,
  output logic [DATA_W-1:0] oA_RDATA,
  output logic              oA_RVALID,
  // client B
  input  logic              iB_REQ,
  input  logic              iB_WE,
  input  logic [ADDR_W-1:0] iB_ADDR,
  input  logic [DATA_W-1:0] iB_WDATA,
  output logic              oB_GNT,
  output logic [DATA_W-1:0] oB_RDATA,
  output logic              oB_RVALID,
  // buffer swap
  input  logic              iSWAP_REQ,
  output logic              oFRONT_SEL,
  output logic              oSWAP_PEND,
  output logic              oSWAP_DONE,
  // SRAM
  output logic [ADDR_W:0]   oSRAM_ADDR,
  output logic [DATA_W-1:0] oSRAM_DQ_O,
  input  logic [DATA_W-1:0] iSRAM_DQ_I,
  output logic              oSRAM_DQ_OE,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N
);

  // Source tags carried with each read through the pipeline.
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_VGA  = 2'd1;
  localparam logic [1:0] SRC_A    = 2'd2;
  localparam logic [1:0] SRC_B    = 2'd3;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic rr_b_reg;   // 1: B wins a tie, 0: A wins a tie
  logic a_gnt;
  logic b_gnt;

  // VGA has no backpressure, so any fetch cycle locks both clients out.
  // Grants are also held low while reset is asserted.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (iRST_N && !iVGA_REQ) begin
      if (iA_REQ && (!iB_REQ || !rr_b_reg)) begin
        a_gnt = 1'b1;
      end else if (iB_REQ) begin
        b_gnt = 1'b1;
      end
    end
  end

  // After any granted client transfer the tie-break moves to the other client.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rr_b_reg <= 1'b0;
    end else if (a_gnt) begin
      rr_b_reg <= 1'b1;
    end else if (b_gnt) begin
      rr_b_reg <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Swap control
  // -------------------------------------------------------------------------
  swap_state_t state_reg;
  swap_state_t state_next;
  logic        vsync_hist_reg;
  logic        front_sel_reg;
  logic        front_sel_next;
  logic        swap_done_reg;
  logic        swap_done_next;
  logic        swap_pend;
  logic        vsync_fall;
  logic        do_swap;

  assign vsync_fall = !iVGA_VSYNC && vsync_hist_reg;
  // A request arriving on the very vsync edge swaps immediately.
  assign do_swap    = vsync_fall && ((state_reg == SWAP_PENDING) || iSWAP_REQ);

  // state register (plus the registered swap outputs and vsync history)
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg      <= SWAP_IDLE;
      vsync_hist_reg <= 1'b1;
      front_sel_reg  <= 1'b0;
      swap_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      vsync_hist_reg <= iVGA_VSYNC;
      front_sel_reg  <= front_sel_next;
      swap_done_reg  <= swap_done_next;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      SWAP_IDLE: begin
        if (iSWAP_REQ && !vsync_fall) begin
          state_next = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (vsync_fall) begin
          state_next = SWAP_IDLE;
        end
      end
      default: state_next = SWAP_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    front_sel_next = front_sel_reg ^ do_swap;
    swap_done_next = do_swap;
    swap_pend      = (state_reg == SWAP_PENDING);
  end

  // -------------------------------------------------------------------------
  // Issue stage
  // -------------------------------------------------------------------------
  logic [1:0]        issue_src_next;
  logic              issue_we_next;
  logic [ADDR_W:0]   issue_addr_next;
  logic [DATA_W-1:0] issue_wdata_next;

  logic [ADDR_W:0]   sram_addr_reg;
  logic [DATA_W-1:0] sram_dq_o_reg;
  logic              sram_dq_oe_reg;
  logic              sram_we_n_reg;
  logic              sram_oe_n_reg;
  logic [1:0]        tag_reg;

  // The buffer bit comes from the front selection at the request edge, so an
  // access in the swap cycle still targets the pre-swap buffer.
  always_comb begin
    issue_src_next   = SRC_NONE;
    issue_we_next    = 1'b0;
    issue_addr_next  = sram_addr_reg;
    issue_wdata_next = sram_dq_o_reg;
    if (iVGA_REQ) begin
      issue_src_next  = SRC_VGA;
      issue_addr_next = {front_sel_reg, iVGA_ADDR};
    end else if (a_gnt) begin
      issue_src_next  = SRC_A;
      issue_we_next   = iA_WE;
      issue_addr_next = {~front_sel_reg, iA_ADDR};
      if (iA_WE) begin
        issue_wdata_next = iA_WDATA;
      end
    end else if (b_gnt) begin
      issue_src_next  = SRC_B;
      issue_we_next   = iB_WE;
      issue_addr_next = {~front_sel_reg, iB_ADDR};
      if (iB_WE) begin
        issue_wdata_next = iB_WDATA;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sram_addr_reg  <= '0;
      sram_dq_o_reg  <= '0;
      sram_dq_oe_reg <= 1'b0;
      sram_we_n_reg  <= 1'b1;
      sram_oe_n_reg  <= 1'b1;
      tag_reg        <= SRC_NONE;
    end else begin
      sram_addr_reg  <= issue_addr_next;
      sram_dq_o_reg  <= issue_wdata_next;
      sram_dq_oe_reg <= (issue_src_next != SRC_NONE) && issue_we_next;
      sram_we_n_reg  <= !((issue_src_next != SRC_NONE) && issue_we_next);
      sram_oe_n_reg  <= !((issue_src_next != SRC_NONE) && !issue_we_next);
      // only reads need a tag; writes return nothing
      tag_reg        <= issue_we_next ? SRC_NONE : issue_src_next;
    end
  end

  // -------------------------------------------------------------------------
  // Read return: one capture register per source (0 = VGA, 1 = A, 2 = B).
  // Data is sampled at the end of the issue cycle; RDATA holds otherwise.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : ret_gen
    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;
    logic              hit;

    assign hit = (tag_reg == 2'(gi + 1));

    always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
        data_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= hit;
        if (hit) begin
          data_reg <= iSRAM_DQ_I;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign oA_GNT      = a_gnt;
  assign oB_GNT      = b_gnt;

  assign oVGA_DATA   = ret_gen[0].data_reg;
  assign oVGA_VALID  = ret_gen[0].valid_reg;
  assign oA_RDATA    = ret_gen[1].data_reg;
  assign oA_RVALID   = ret_gen[1].valid_reg;
  assign oB_RDATA    = ret_gen[2].data_reg;
  assign oB_RVALID   = ret_gen[2].valid_reg;

  assign oFRONT_SEL  = front_sel_reg;
  assign oSWAP_PEND  = swap_pend;
  assign oSWAP_DONE  = swap_done_reg;

  assign oSRAM_ADDR  = sram_addr_reg;
  assign oSRAM_DQ_O  = sram_dq_o_reg;
  assign oSRAM_DQ_OE = sram_dq_oe_reg;
  assign oSRAM_WE_N  = sram_we_n_reg;
  assign oSRAM_OE_N  = sram_oe_n_reg;

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_sram_arbiter
//
// Bench for fb_sram_arbiter: an asynchronous-read SRAM model, directed
// scenario tasks and a randomized run checked against a transaction-level
// model of arbitration, double buffering and read return.
// ---------------------------------------------------------------------------
module tb_fb_sram_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic          vga_valid;
  logic          vga_vsync;
  logic          a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid;
  logic          swap_req;
  logic          front_sel, swap_pend, swap_done;
  logic [AW:0]   sram_addr;
  logic [DW-1:0] sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_we_n, sram_oe_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iVGA_REQ(vga_req), .iVGA_ADDR(vga_addr), .oVGA_DATA(vga_data),
    .oVGA_VALID(vga_valid), .iVGA_VSYNC(vga_vsync),
    .iA_REQ(a_req), .iB_REQ(b_req), .iA_WE(a_we), .iB_WE(b_we),
    .iA_ADDR(a_addr), .iB_ADDR(b_addr), .iA_WDATA(a_wdata), .iB_WDATA(b_wdata),
    .oA_GNT(a_gnt), .oB_GNT(b_gnt), .oA_RDATA(a_rdata), .oB_RDATA(b_rdata),
    .oA_RVALID(a_rvalid), .oB_RVALID(b_rvalid),
    .iSWAP_REQ(swap_req), .oFRONT_SEL(front_sel), .oSWAP_PEND(swap_pend),
    .oSWAP_DONE(swap_done),
    .oSRAM_ADDR(sram_addr), .oSRAM_DQ_O(sram_dq_o), .iSRAM_DQ_I(sram_dq_i),
    .oSRAM_DQ_OE(sram_dq_oe), .oSRAM_WE_N(sram_we_n), .oSRAM_OE_N(sram_oe_n)
  );

  // SRAM model: asynchronous read while OE_N is low, write on the clock edge
  // that ends a cycle with WE_N low and DQ driven.
  logic [DW-1:0] mem [0:(1<<(AW+1))-1];
  assign sram_dq_i = sram_oe_n ? {DW{1'b1}} : mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
  end

  function automatic logic [DW-1:0] init_val(input logic [AW:0] a);
    logic [31:0] t;
    t = {13'd0, a} * 32'd40503;
    return t[15:0] ^ {a[18:16], 13'h1a5};
  endfunction

  // Reference memory contents seen by the random run (physical address).
  logic [DW-1:0] exp_mem [logic [AW:0]];

  typedef struct {
    int          src;   // 0 none, 1 VGA, 2 A, 3 B
    logic        we;
    logic [AW:0] pa;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
  } xfer_t;

  task automatic drive_idle();
    vga_req = 1'b0;
    a_req   = 1'b0;
    b_req   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    swap_req  = 1'b0;
    vga_vsync = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    a_req = 1'b1;
    b_req = 1'b1;
    #1;
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, vga_valid, front_sel, swap_pend, swap_done,
         sram_dq_oe, sram_we_n, sram_oe_n} !== 11'b00000000011) begin
      errors++;
      $display("FAIL reset_status: got %b expected %b",
               {a_gnt, b_gnt, a_rvalid, b_rvalid, vga_valid, front_sel, swap_pend, swap_done,
                sram_dq_oe, sram_we_n, sram_oe_n}, 11'b00000000011);
    end
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({a_rdata, b_rdata, vga_data, sram_dq_o, sram_addr} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {a_rdata, b_rdata, vga_data, sram_dq_o, sram_addr});
    end
    checks++;
    if ({a_rvalid, b_rvalid, vga_valid, front_sel, swap_pend, swap_done,
         sram_dq_oe, sram_we_n, sram_oe_n} !== 9'b000000011) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b",
               {a_rvalid, b_rvalid, vga_valid, front_sel, swap_pend, swap_done,
                sram_dq_oe, sram_we_n, sram_oe_n}, 9'b000000011);
    end
    $display("reset: outputs checked in and after reset");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_client_rw();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 18'h00010; a_wdata = 16'h1234;
    #1;
    checks++;
    if (a_gnt !== 1'b1) begin errors++; $display("FAIL a_write_gnt: got %b expected 1", a_gnt); end
    $display("A write addr %h data %h", a_addr, a_wdata);
    @(negedge clk);
    a_we = 1'b0;   // same request line, now a read of the same word
    #1;
    checks++;
    if ({sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_o} !== {19'h40010, 3'b011, 16'h1234}) begin
      errors++;
      $display("FAIL a_write_issue: got %h/%b%b%b/%h expected 40010/011/1234",
               sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_o);
    end
    checks++;
    if (a_gnt !== 1'b1) begin errors++; $display("FAIL a_read_gnt: got %b expected 1", a_gnt); end
    $display("A read addr %h", a_addr);
    @(negedge clk);
    a_req = 1'b0;
    #1;
    checks++;
    if ({sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, a_rvalid} !== {19'h40010, 4'b1000}) begin
      errors++;
      $display("FAIL a_read_issue: got %h/%b%b%b valid %b expected 40010/100 valid 0",
               sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, a_rvalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({a_rvalid, a_rdata} !== {1'b1, 16'h1234}) begin
      errors++;
      $display("FAIL a_read_return: got valid %b data %h expected valid 1 data 1234", a_rvalid, a_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({a_rvalid, a_rdata} !== {1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL a_rdata_hold: got valid %b data %h expected valid 0 data 1234", a_rvalid, a_rdata);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_vga_priority_rr();
    do_reset();
    @(negedge clk);
    vga_req = 1'b1; vga_addr = '0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 18'h20; a_wdata = 16'hA001;
    b_req = 1'b1; b_we = 1'b1; b_addr = 18'h30; b_wdata = 16'hB001;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      vga_addr = 18'(c);
      #1;
      checks++;
      if ({a_gnt, b_gnt} !== 2'b00) begin
        errors++;
        $display("FAIL vga_blocks_clients c%0d: got %b expected 00", c, {a_gnt, b_gnt});
      end
    end
    @(negedge clk);
    vga_req = 1'b0;
    #1;
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin errors++; $display("FAIL rr_first: got %b expected 10", {a_gnt, b_gnt}); end
    $display("A write addr %h data %h (after VGA)", a_addr, a_wdata);
    @(negedge clk);
    a_addr = 18'h21; a_wdata = 16'hA002;
    #1;
    checks++;
    if ({a_gnt, b_gnt} !== 2'b01) begin errors++; $display("FAIL rr_second: got %b expected 01", {a_gnt, b_gnt}); end
    checks++;
    if ({sram_addr, sram_dq_o, sram_we_n} !== {19'h40020, 16'hA001, 1'b0}) begin
      errors++;
      $display("FAIL rr_issue_a: got %h/%h/%b expected 40020/a001/0", sram_addr, sram_dq_o, sram_we_n);
    end
    $display("B write addr %h data %h", b_addr, b_wdata);
    @(negedge clk);
    b_addr = 18'h31; b_wdata = 16'hB002;
    #1;
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin errors++; $display("FAIL rr_third: got %b expected 10", {a_gnt, b_gnt}); end
    checks++;
    if ({sram_addr, sram_dq_o, sram_we_n} !== {19'h40030, 16'hB001, 1'b0}) begin
      errors++;
      $display("FAIL rr_issue_b: got %h/%h/%b expected 40030/b001/0", sram_addr, sram_dq_o, sram_we_n);
    end
    $display("A write addr %h data %h", a_addr, a_wdata);
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({sram_addr, sram_dq_o, sram_we_n} !== {19'h40021, 16'hA002, 1'b0}) begin
      errors++;
      $display("FAIL rr_issue_a2: got %h/%h/%b expected 40021/a002/0", sram_addr, sram_dq_o, sram_we_n);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_vga_burst();
    repeat (3) @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      vga_req  = (c < 8);
      vga_addr = 18'(c);
      if (c < 8) $display("VGA read addr %h", vga_addr);
      #1;
      checks++;
      if (vga_valid !== ((c >= 2) && (c < 10))) begin
        errors++;
        $display("FAIL vga_burst_valid c%0d: got %b expected %b", c, vga_valid, (c >= 2) && (c < 10));
      end
      if ((c >= 2) && (c < 10)) begin
        checks++;
        if (vga_data !== init_val(19'(c - 2))) begin
          errors++;
          $display("FAIL vga_burst_data c%0d: got %h expected %h", c, vga_data, init_val(19'(c - 2)));
        end
      end
      if ((c >= 1) && (c <= 8)) begin
        checks++;
        if (sram_addr !== 19'(c - 1)) begin
          errors++;
          $display("FAIL vga_burst_addr c%0d: got %h expected %h", c, sram_addr, 19'(c - 1));
        end
      end
    end
    drive_idle();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_swap_pending();
    @(negedge clk);
    swap_req = 1'b1;
    $display("swap request (mid-frame)");
    @(negedge clk);
    swap_req = 1'b0;
    #1;
    checks++;
    if ({front_sel, swap_pend, swap_done} !== 3'b010) begin
      errors++; $display("FAIL swap_pend_set: got %b expected 010", {front_sel, swap_pend, swap_done});
    end
    @(negedge clk);
    swap_req = 1'b1;   // repeated request while pending
    @(negedge clk);
    swap_req = 1'b0;
    vga_vsync = 1'b0;
    #1;
    checks++;
    if ({front_sel, swap_pend, swap_done} !== 3'b010) begin
      errors++; $display("FAIL swap_wait: got %b expected 010", {front_sel, swap_pend, swap_done});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({front_sel, swap_pend, swap_done} !== 3'b101) begin
      errors++; $display("FAIL swap_at_vsync: got %b expected 101", {front_sel, swap_pend, swap_done});
    end
    @(negedge clk);
    vga_req = 1'b1; vga_addr = 18'h5;
    #1;
    checks++;
    if ({front_sel, swap_pend, swap_done} !== 3'b100) begin
      errors++; $display("FAIL swap_done_once: got %b expected 100", {front_sel, swap_pend, swap_done});
    end
    @(negedge clk);
    vga_req = 1'b0;
    vga_vsync = 1'b1;
    #1;
    checks++;
    if (sram_addr !== 19'h40005) begin
      errors++; $display("FAIL swap_vga_buffer: got %h expected 40005", sram_addr);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_swap_immediate();
    @(negedge clk);
    swap_req = 1'b1;
    vga_vsync = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 18'h50; b_wdata = 16'h5A5A;
    #1;
    checks++;
    if (b_gnt !== 1'b1) begin errors++; $display("FAIL swap_cycle_gnt: got %b expected 1", b_gnt); end
    $display("swap request on vsync edge, B write addr %h data %h", b_addr, b_wdata);
    @(negedge clk);
    swap_req = 1'b0;
    drive_idle();
    #1;
    checks++;
    if ({front_sel, swap_pend, swap_done} !== 3'b001) begin
      errors++; $display("FAIL swap_immediate: got %b expected 001", {front_sel, swap_pend, swap_done});
    end
    checks++;
    if (sram_addr !== 19'h00050) begin
      errors++; $display("FAIL swap_cycle_buffer: got %h expected 00050", sram_addr);
    end
    @(negedge clk);
    vga_vsync = 1'b1;
    @(negedge clk);
    vga_vsync = 1'b0;   // edge with nothing pending
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({front_sel, swap_pend, swap_done} !== 3'b000) begin
        errors++; $display("FAIL swap_no_req c%0d: got %b expected 000", c, {front_sel, swap_pend, swap_done});
      end
    end
    vga_vsync = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_midop();
    @(negedge clk);
    swap_req = 1'b1; vga_vsync = 1'b0;   // immediate swap -> front 1
    @(negedge clk);
    swap_req = 1'b0; vga_vsync = 1'b1;
    @(negedge clk);
    swap_req = 1'b1;                      // leave a swap pending
    @(negedge clk);
    swap_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 18'h10;
    #1;
    checks++;
    if ({a_gnt, front_sel, swap_pend} !== 3'b111) begin
      errors++; $display("FAIL midop_setup: got %b expected 111", {a_gnt, front_sel, swap_pend});
    end
    $display("A read addr %h then reset", a_addr);
    @(negedge clk);
    a_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_rvalid, b_rvalid, vga_valid, front_sel, swap_pend, swap_done,
         sram_dq_oe, sram_we_n, sram_oe_n, sram_addr, a_rdata} !== {9'b000000011, 19'h0, 16'h0}) begin
      errors++;
      $display("FAIL midop_reset_state: got %b/%h/%h expected 000000011/0/0",
               {a_rvalid, b_rvalid, vga_valid, front_sel, swap_pend, swap_done,
                sram_dq_oe, sram_we_n, sram_oe_n}, sram_addr, a_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({a_rvalid, b_rvalid, vga_valid, front_sel, swap_pend} !== 5'b00000) begin
        errors++;
        $display("FAIL midop_no_valid c%0d: got %b expected 00000", c,
                 {a_rvalid, b_rvalid, vga_valid, front_sel, swap_pend});
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_random();
    xfer_t         st1, st2, cur;
    logic          rr_a, m_front, m_pend, m_done, m_prev_vs;
    logic          a_pend, b_pend, fall, do_swap;
    logic [DW-1:0] last_rd [3];
    logic [2:0]    exp_valid;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] got_rd;
    int            winner;

    do_reset();
    rr_a = 1'b1; m_front = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_prev_vs = 1'b1;
    a_pend = 1'b0; b_pend = 1'b0;
    st1 = '{default: 0};
    st2 = '{default: 0};
    for (int i = 0; i < 3; i++) last_rd[i] = '0;

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      vga_req  = ($urandom_range(0, 2) == 0);
      vga_addr = 18'h100 + 18'($urandom_range(0, 31));
      if (!a_pend && $urandom_range(0, 1) == 1) begin
        a_pend = 1'b1; a_we = 1'($urandom_range(0, 1));
        a_addr = 18'h100 + 18'($urandom_range(0, 31)); a_wdata = 16'($urandom);
      end
      if (!b_pend && $urandom_range(0, 1) == 1) begin
        b_pend = 1'b1; b_we = 1'($urandom_range(0, 1));
        b_addr = 18'h100 + 18'($urandom_range(0, 31)); b_wdata = 16'($urandom);
      end
      a_req = a_pend;
      b_req = b_pend;
      swap_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) vga_vsync = ~vga_vsync;
      #1;

      // who owns the SRAM this cycle
      if (vga_req) winner = 1;
      else if (a_pend && b_pend) winner = rr_a ? 2 : 3;
      else if (a_pend) winner = 2;
      else if (b_pend) winner = 3;
      else winner = 0;

      checks++;
      if ({a_gnt, b_gnt} !== {winner == 2, winner == 3}) begin
        errors++;
        $display("FAIL rnd_gnt n%0d: got %b expected %b", n, {a_gnt, b_gnt}, {winner == 2, winner == 3});
      end
      checks++;
      if ({front_sel, swap_pend, swap_done} !== {m_front, m_pend, m_done}) begin
        errors++;
        $display("FAIL rnd_swap n%0d: got %b expected %b", n, {front_sel, swap_pend, swap_done},
                 {m_front, m_pend, m_done});
      end

      // previous cycle's access on the SRAM pins
      checks++;
      if (st1.src == 0) begin
        if ({sram_we_n, sram_oe_n, sram_dq_oe} !== 3'b110) begin
          errors++;
          $display("FAIL rnd_idle n%0d: got %b expected 110", n, {sram_we_n, sram_oe_n, sram_dq_oe});
        end
      end else if ({sram_addr, sram_we_n, sram_oe_n, sram_dq_oe} !==
                   {st1.pa, (st1.we ? 3'b011 : 3'b100)}) begin
        errors++;
        $display("FAIL rnd_issue n%0d: got %h/%b expected %h/%b", n, sram_addr,
                 {sram_we_n, sram_oe_n, sram_dq_oe}, st1.pa, (st1.we ? 3'b011 : 3'b100));
      end
      if (st1.src != 0 && st1.we) begin
        checks++;
        if (sram_dq_o !== st1.wd) begin
          errors++; $display("FAIL rnd_wdata n%0d: got %h expected %h", n, sram_dq_o, st1.wd);
        end
      end

      // read return from two cycles back
      exp_valid = {st2.src == 1 && !st2.we, st2.src == 2 && !st2.we, st2.src == 3 && !st2.we};
      checks++;
      if ({vga_valid, a_rvalid, b_rvalid} !== exp_valid) begin
        errors++;
        $display("FAIL rnd_valid n%0d: got %b expected %b", n, {vga_valid, a_rvalid, b_rvalid}, exp_valid);
      end
      for (int s = 0; s < 3; s++) begin
        if (exp_valid[2 - s]) last_rd[s] = st2.rd;
        exp_rd = last_rd[s];
        got_rd = (s == 0) ? vga_data : (s == 1) ? a_rdata : b_rdata;
        checks++;
        if (got_rd !== exp_rd) begin
          errors++; $display("FAIL rnd_rdata n%0d src%0d: got %h expected %h", n, s, got_rd, exp_rd);
        end
      end

      // record this cycle's access against the reference memory
      cur = '{default: 0};
      cur.src = winner;
      if (winner == 1) begin
        cur.pa = {m_front, vga_addr};
      end else if (winner == 2) begin
        cur.we = a_we; cur.pa = {~m_front, a_addr}; cur.wd = a_wdata;
      end else if (winner == 3) begin
        cur.we = b_we; cur.pa = {~m_front, b_addr}; cur.wd = b_wdata;
      end
      if (winner != 0) begin
        if (cur.we) exp_mem[cur.pa] = cur.wd;
        else cur.rd = exp_mem.exists(cur.pa) ? exp_mem[cur.pa] : init_val(cur.pa);
        $display("rnd %0d src %0d %s addr %h data %h", n, winner, cur.we ? "wr" : "rd",
                 cur.pa, cur.we ? cur.wd : cur.rd);
      end

      // state after the coming clock edge
      fall    = !vga_vsync && m_prev_vs;
      do_swap = fall && (m_pend || swap_req);
      m_done  = do_swap;
      if (do_swap) begin
        m_front = ~m_front;
        m_pend  = 1'b0;
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
      m_prev_vs = vga_vsync;
      if (winner == 2) begin rr_a = 1'b0; a_pend = 1'b0; end
      if (winner == 3) begin rr_a = 1'b1; b_pend = 1'b0; end
      st2 = st1;
      st1 = cur;
    end
    @(negedge clk);
    drive_idle();
    swap_req = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < (1 << (AW + 1)); i++) mem[i] = init_val(19'(i));
    rst_n = 1'b0;
    drive_idle();
    a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; vga_addr = '0;
    a_wdata = '0; b_wdata = '0;
    swap_req = 1'b0;
    vga_vsync = 1'b1;

    test_reset();
    test_client_rw();
    test_vga_priority_rr();
    test_vga_burst();
    test_swap_pending();
    test_swap_immediate();
    test_reset_midop();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
